// File: rtl/carregador_programa_pkg.sv
// Shared processor package: program-loader state encoding and default loader geometry.
package carregador_programa_pkg;

  localparam int unsigned DefAddrW        = 8;
  localparam int unsigned DefDataW        = 16;
  localparam int unsigned DefTimeout      = 1024;
  // Number of cycles the processor is held in reset before execution starts.
  localparam int unsigned ResetProcCycles = 2;

  typedef enum logic [2:0] {
    StOcioso,
    StCarga,
    StResetProc,
    StExecuta,
    StFim
  } estado_e;

  function automatic logic estado_busy(estado_e st);
    return (st == StCarga) || (st == StResetProc) || (st == StExecuta);
  endfunction

endpackage

// File: rtl/carregador_programa_if.sv
// Instruction stream input and program-ROM write port of the program loader.
interface carregador_programa_if
  import carregador_programa_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/carregador_programa.sv
// Program loader: streams words into program ROM, resets the processor, runs it under a
// watchdog and captures the top of stack when it halts or times out.
module carregador_programa
  import carregador_programa_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  carregador_programa_if.slave bus,
  output logic                 reset_UC,
  output logic                 reset_datapath,
  input  logic                 halt,
  input  logic [DATA_W-1:0]    tos,
  output logic                 busy,
  output logic                 done,
  output logic                 erro,
  output logic [DATA_W-1:0]    resultado
);

  // Cycle counter is shared by the reset window and the execution watchdog.
  localparam int unsigned     CycW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CycW-1:0] CycLast = CycW'(TIMEOUT - 1);
  localparam logic [CycW-1:0] RpLast  = CycW'(ResetProcCycles - 1);

  estado_e           state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [CycW-1:0]   cyc_q, cyc_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              erro_q, erro_d;
  logic [DATA_W-1:0] resultado_q, resultado_d;
  logic              accept;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StOcioso;
      cnt_q       <= '0;
      cyc_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      erro_q      <= 1'b0;
      resultado_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      erro_q      <= erro_d;
      resultado_q <= resultado_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    erro_d      = erro_q;
    resultado_d = resultado_q;
    accept      = (state_q == StCarga) && bus.in_valid;

    unique case (state_q)
      StOcioso, StFim: begin
        if (start) begin
          state_d = StCarga;
          cnt_d   = '0;
          done_d  = 1'b0;
          erro_d  = 1'b0;
        end
      end
      StCarga: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q;
          mem_wdata_d = bus.in_data;
          // Counter saturates at the top address so it never wraps back to 0.
          if (!(&cnt_q)) begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
          if (bus.in_last) begin
            state_d = StResetProc;
            cyc_d   = '0;
          end else if (&cnt_q) begin
            state_d = StFim;
            erro_d  = 1'b1;
          end
        end
      end
      StResetProc: begin
        if (cyc_q == RpLast) begin
          state_d = StExecuta;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StExecuta: begin
        if (halt) begin
          resultado_d = tos;
          done_d      = 1'b1;
          state_d     = StFim;
        end else if (cyc_q == CycLast) begin
          resultado_d = tos;
          erro_d      = 1'b1;
          state_d     = StFim;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      default: state_d = StOcioso;
    endcase
  end

  assign bus.in_ready  = (state_q == StCarga);
  // A write still pending when reset arrives is dropped.
  assign bus.mem_we    = mem_we_q & ~reset;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign reset_UC       = (state_q != StExecuta);
  assign reset_datapath = (state_q != StExecuta);
  assign busy           = estado_busy(state_q);
  assign done           = done_q;
  assign erro           = erro_q;
  assign resultado      = resultado_q;

endmodule

// File: tb/tb_carregador_programa.sv
// Randomized self-checking bench for carregador_programa: two instances (wide and 2-bit
// address) compared against a transaction-level model of loads and executions.
module tb_carregador_programa;
  import carregador_programa_pkg::*;

  localparam int unsigned AwA = 8;
  localparam int unsigned AwB = 2;
  localparam int unsigned Dw  = 16;
  localparam int          Tmo = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, start_a, start_b, halt;
  logic          s_valid, s_last;
  logic [Dw-1:0] s_data, tos;
  logic          ruc_a, rdp_a, busy_a, done_a, erro_a;
  logic          ruc_b, rdp_b, busy_b, done_b, erro_b;
  logic [Dw-1:0] res_a, res_b;

  carregador_programa_if #(.ADDR_W(AwA), .DATA_W(Dw)) ifa ();
  carregador_programa_if #(.ADDR_W(AwB), .DATA_W(Dw)) ifb ();

  assign ifa.in_valid = s_valid;
  assign ifa.in_data  = s_data;
  assign ifa.in_last  = s_last;
  assign ifb.in_valid = s_valid;
  assign ifb.in_data  = s_data;
  assign ifb.in_last  = s_last;

  carregador_programa #(.ADDR_W(AwA), .DATA_W(Dw), .TIMEOUT(Tmo)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .bus(ifa),
    .reset_UC(ruc_a), .reset_datapath(rdp_a), .halt(halt), .tos(tos),
    .busy(busy_a), .done(done_a), .erro(erro_a), .resultado(res_a)
  );

  carregador_programa #(.ADDR_W(AwB), .DATA_W(Dw), .TIMEOUT(Tmo)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .bus(ifb),
    .reset_UC(ruc_b), .reset_datapath(rdp_b), .halt(halt), .tos(tos),
    .busy(busy_b), .done(done_b), .erro(erro_b), .resultado(res_b)
  );

  int sel;  // 0 selects dut_a, 1 selects dut_b
  logic          o_ready, o_we, o_ruc, o_rdp, o_busy, o_done, o_erro;
  logic [31:0]   o_addr;
  logic [Dw-1:0] o_wdata, o_res;

  always_comb begin
    if (sel == 0) begin
      o_ready = ifa.in_ready;  o_we = ifa.mem_we;  o_addr = 32'(ifa.mem_addr);
      o_wdata = ifa.mem_wdata; o_ruc = ruc_a;      o_rdp = rdp_a;
      o_busy = busy_a; o_done = done_a; o_erro = erro_a; o_res = res_a;
    end else begin
      o_ready = ifb.in_ready;  o_we = ifb.mem_we;  o_addr = 32'(ifb.mem_addr);
      o_wdata = ifb.mem_wdata; o_ruc = ruc_b;      o_rdp = rdp_b;
      o_busy = busy_b; o_done = done_b; o_erro = erro_b; o_res = res_b;
    end
  end

  typedef struct {
    int dut;
    int addr;
    int data;
  } wr_t;

  wr_t wq[$];      // observed ROM writes
  int  words[$];   // words the model expects to be written, in address order
  int  fixed_q[$]; // optional fixed payload for directed loads

  always @(negedge clock) begin
    #2;
    if (ifa.mem_we === 1'b1)
      wq.push_back('{dut: 0, addr: int'(ifa.mem_addr), data: int'(ifa.mem_wdata)});
    if (ifb.mem_we === 1'b1)
      wq.push_back('{dut: 1, addr: int'(ifb.mem_addr), data: int'(ifb.mem_wdata)});
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic set_start(input int s, input logic v);
    start_a = (s == 0) ? v : 1'b0;
    start_b = (s == 1) ? v : 1'b0;
  endtask

  task automatic check_reset_vals();
    #1;
    check_eq("rst_ready", o_ready, 0);
    check_eq("rst_we", o_we, 0);
    check_eq("rst_addr", o_addr, 0);
    check_eq("rst_wdata", o_wdata, 0);
    check_eq("rst_resets", {o_ruc, o_rdp}, 2'b11);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_done", o_done, 0);
    check_eq("rst_erro", o_erro, 0);
    check_eq("rst_res", o_res, 0);
  endtask

  // Pulse start from idle/finished; the block must be loading on the next cycle.
  task automatic do_start(input int s);
    sel = s;
    set_start(s, 1'b1);
    @(negedge clock);
    set_start(s, 1'b0);
    check_eq("start_busy", o_busy, 1);
    check_eq("start_done", o_done, 0);
    check_eq("start_erro", o_erro, 0);
    check_eq("start_ready", o_ready, 1);
  endtask

  // gap_mode: 0 back-to-back, 1 alternate valid/idle, 2 random idles.
  task automatic load(input int s, input int n, input int gap_mode, input bit with_last);
    int cap;
    cap = (s == 0) ? (1 << AwA) : (1 << AwB);
    words.delete();
    for (int i = 0; i < n && i < cap; i++) begin
      int idles;
      idles = (gap_mode == 1 && i > 0) ? 1 :
              (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int j = 0; j < idles; j++) begin
        s_valid = 1'b0;
        s_data  = Dw'($urandom);
        s_last  = 1'($urandom);
        set_start(s, 1'($urandom));
        @(negedge clock);
      end
      s_valid = 1'b1;
      s_data  = (i < fixed_q.size()) ? Dw'(fixed_q[i]) : Dw'($urandom);
      s_last  = with_last && (i == n - 1);
      set_start(s, 1'($urandom));
      check_eq("load_ready", o_ready, 1);
      words.push_back(int'(s_data));
      @(negedge clock);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    set_start(s, 1'b0);
  endtask

  task automatic check_writes();
    check_eq("wr_count", wq.size(), words.size());
    foreach (words[i]) begin
      if (i < wq.size()) begin
        check_eq("wr_dut", wq[i].dut, sel);
        check_eq("wr_addr", wq[i].addr, i);
        check_eq("wr_data", wq[i].data, words[i]);
      end
    end
    wq.delete();
  endtask

  // Called on the first cycle after the last word: two reset cycles, then execution.
  task automatic to_exec();
    check_eq("rp1_resets", {o_ruc, o_rdp}, 2'b11);
    check_eq("rp1_busy", o_busy, 1);
    @(negedge clock);
    check_eq("rp2_resets", {o_ruc, o_rdp}, 2'b11);
    @(negedge clock);
    check_eq("exec_resets", {o_ruc, o_rdp}, 2'b00);
  endtask

  // halt_at < 0 means halt is never raised; result follows the halt/watchdog rules.
  task automatic run_exec(input int halt_at, input int tos_fix);
    logic [Dw-1:0] exp_res;
    bit            exp_done;
    bit            fin;
    exp_res  = '0;
    exp_done = 1'b0;
    fin      = 1'b0;
    for (int k = 0; k < Tmo && !fin; k++) begin
      halt = (k == halt_at);
      tos  = (halt && tos_fix >= 0) ? Dw'(tos_fix) : Dw'($urandom);
      set_start(sel, 1'($urandom));
      check_eq("exec_busy", o_busy, 1);
      check_eq("exec_ruc", o_ruc, 0);
      if (halt || k == Tmo - 1) begin
        exp_res  = tos;
        exp_done = halt;
        fin      = 1'b1;
      end
      @(negedge clock);
    end
    halt = 1'b0;
    set_start(sel, 1'b0);
    for (int j = 0; j < 3; j++) begin
      tos = Dw'($urandom);
      check_eq("fim_done", o_done, exp_done);
      check_eq("fim_erro", o_erro, !exp_done);
      check_eq("fim_res", o_res, exp_res);
      check_eq("fim_busy", o_busy, 0);
      check_eq("fim_resets", {o_ruc, o_rdp}, 2'b11);
      @(negedge clock);
    end
  endtask

  task automatic check_overflow();
    check_eq("ovf_erro", o_erro, 1);
    check_eq("ovf_done", o_done, 0);
    check_eq("ovf_busy", o_busy, 0);
    check_eq("ovf_ready", o_ready, 0);
    repeat (2) @(negedge clock);
    check_writes();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; halt = 1'b0; tos = '0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; sel = 0;
    repeat (3) @(negedge clock);
    sel = 0; check_reset_vals();
    sel = 1; check_reset_vals();
    reset = 1'b0;
    @(negedge clock);

    // Three fixed words, then halt with tos = 8.
    fixed_q = '{16'h0005, 16'h0003, 16'h0010};
    do_start(0);
    load(0, 3, 0, 1'b1);
    fixed_q.delete();
    check_eq("last_we", o_we, 1);
    to_exec();
    check_writes();
    run_exec(4, 8);

    // Alternating valid, then run into the watchdog.
    do_start(0);
    load(0, 4, 1, 1'b1);
    to_exec();
    check_writes();
    run_exec(-1, -1);

    // 2-bit address space filled without in_last.
    do_start(1);
    load(1, 4, 2, 1'b0);
    check_overflow();

    // Reset right after the second word is accepted.
    do_start(0);
    load(0, 2, 0, 1'b0);
    reset   = 1'b1;
    #1;
    check_eq("rst_pending_we", o_we, 0);
    @(negedge clock);
    check_reset_vals();
    reset = 1'b0;
    void'(words.pop_back());
    check_writes();
    do_start(0);
    load(0, 3, 2, 1'b1);
    to_exec();
    check_writes();
    run_exec(Tmo - 1, -1);

    repeat (12) begin
      int s, n, h;
      s = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 6));
      h = int'($urandom_range(0, 19));
      do_start(s);
      load(s, n, 2, 1'b1);
      if (s == 1 && n > (1 << AwB)) begin
        check_overflow();
      end else begin
        to_exec();
        check_writes();
        run_exec((h < Tmo) ? h : -1, -1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/carregador_programa.md
CARREGADOR_PROGRAMA -- requirements
Module: carregador_programa

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the program memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning the instruction and TOS word width.
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of execution cycles before abort.
REQ-004 SHALL have ports: clock  in  1  sole clock, rising edge; reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: start  in  1  begin load; in_valid  in  1; in_ready  out  1; in_data  in  DATA_W  instruction word; in_last  in  1  final word.
REQ-006 SHALL have ports: mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  (program ROM write port).
REQ-007 SHALL have ports: reset_UC  out  1; reset_datapath  out  1  (processor resets); halt  in  1  processor finished; tos  in  DATA_W  processor top of stack.
REQ-008 SHALL have ports: busy  out  1; done  out  1; erro  out  1; resultado  out  DATA_W  captured TOS.
REQ-009 SHALL use one clock, with reset synchronous and active-high.

Function
REQ-010 SHALL implement FSM states OCIOSO, CARGA, RESET_PROC, EXECUTA, FIM.
REQ-011 In OCIOSO, start=1 SHALL go to CARGA next cycle, clear the word counter, done and erro, and set busy=1; start SHALL be ignored in CARGA, RESET_PROC and EXECUTA.
REQ-012 In CARGA, in_ready SHALL be 1, and a word SHALL be accepted only in a cycle with in_valid=1 and in_ready=1.
REQ-013 Each accepted word SHALL produce, on the next cycle, mem_we=1 with mem_addr equal to the word counter and mem_wdata equal to in_data; the counter then increments (write latency 1 cycle).
REQ-014 mem_we SHALL be 1 only for exactly one cycle per accepted word.
REQ-015 Accepting a word with in_last=1 SHALL transition to RESET_PROC.
REQ-016 Accepting word index 2^ADDR_W-1 without in_last SHALL write it, set erro=1 and go to FIM (overflow); no address wrap-around SHALL occur.
REQ-017 In RESET_PROC, reset_UC and reset_datapath SHALL be held 1 for exactly 2 cycles, then both deasserted in the same cycle on entry to EXECUTA.
REQ-018 In OCIOSO, CARGA, RESET_PROC and FIM, reset_UC and reset_datapath SHALL both be 1.
REQ-019 In EXECUTA, a cycle counter SHALL start at 0 and increment each cycle.
REQ-020 In EXECUTA, halt=1 SHALL register tos into resultado, set done=1 and go to FIM.
REQ-021 In EXECUTA, when the counter reaches TIMEOUT-1 with halt=0, the block SHALL register tos into resultado, set erro=1, keep done=0 and go to FIM; if halt=1 in the same cycle, halt SHALL win.
REQ-022 In FIM, busy SHALL be 0, and done, erro and resultado SHALL hold.
REQ-023 In FIM, start=1 SHALL go to CARGA, clearing done, erro and the counter (reload).
REQ-024 busy SHALL be 1 exactly in CARGA, RESET_PROC and EXECUTA.

Reset
REQ-025 reset=1 SHALL, at the next edge, force OCIOSO from any state, including mid-load and mid-execution.
REQ-026 Reset values SHALL be: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, reset_UC=1, reset_datapath=1, busy=0, done=0, erro=0, resultado=0.
REQ-027 A word pending from the accept cycle preceding reset SHALL NOT be written (mem_we=0 after reset).

Structure
REQ-028 State encoding and the default widths/TIMEOUT SHALL reside in the shared processor package alongside the existing datapath constants.
REQ-029 The block SHALL be a single FSM module with no sub-modules; the execution watchdog SHALL remain inline.

Verification
REQ-030 SHALL cover: start, then 3 words 16'h0005, 16'h0003, 16'h0010 (last) with in_valid held -> mem_we pulses at addr 0, 1, 2 with those data, then resets 1 for 2 cycles, then 0.
REQ-031 SHALL cover: in_valid toggled 1/0 during load -> only the 4 valid-cycle words are written, at addr 0-3, with no gaps in addresses.
REQ-032 SHALL cover: in EXECUTA, halt=1 with tos=16'd8 -> resultado=8, done=1, erro=0, busy=0, resets=1 next cycle.
REQ-033 SHALL cover: TIMEOUT=16 with halt never asserted -> erro=1 after 16 EXECUTA cycles, done=0, and resultado equals tos at the abort cycle.
REQ-034 SHALL cover: ADDR_W=2 with 4 words and no in_last -> 4 writes, then erro=1 and FIM, with no write to addr 0 again.
REQ-035 SHALL cover: reset asserted the cycle after word 1 is accepted -> no mem_we, all REQ-026 values, and a following start reloads from addr 0.
